alphamission_side_vram_access: RTL and testbench

CPU-side access sequencer for the side-layer (fixed-character) VRAM. It turns a simple CPU request (chip select, read/write strobe, 11-bit address, data) into the side-VRAM bus control sequence consumed by the side renderer:
- chip select and CPU/video address-mux select;
- bus-transceiver enable and direction;
- SRAM output-enable and write-enable.

It returns read data and a wait signal to the CPU. It sits between the main CPU address decoder and the side renderer, on the common video data bus.

---
 rtl/alphamission_side_pkg.sv | 22 ++
 rtl/side_access_timer.sv | 35 +++
 rtl/alphamission_side_vram_access.sv | 194 +++++++++++++++++++
 tb/tb_alphamission_side_vram_access.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alphamission_side_pkg.sv
// Shared definitions for the side-layer VRAM CPU access sequencer:
// the sequencer state type, default timing parameters and the VRAM address width.
package alphamission_side_pkg;

  localparam int SIDE_VRAM_AW   = 11;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } side_acc_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/side_access_timer.sv
// Loadable down-counter with a terminal-count flag; paces the SETUP and
// STROBE phases of a VRAM access sequencer.
module side_access_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/alphamission_side_vram_access.sv
// CPU-side access sequencer for the side-layer VRAM: converts a CPU request into
// registered chip-select / mux / transceiver / OE / WE sequencing and returns read data.
module alphamission_side_vram_access
  import alphamission_side_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC
) (
  input  logic                    clk,
  input  logic                    VIDEO_RST,
  input  logic                    cpu_cs,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [SIDE_VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]              cpu_din,
  input  logic                    cpu_slot,
  output logic [7:0]              cpu_dout,
  output logic                    cpu_waitn,
  output logic                    SIDE_VRAM_CSn,
  output logic                    V_C,
  output logic [SIDE_VRAM_AW-1:0] VA,
  output logic [7:0]              VD_out,
  input  logic [7:0]              VD_in,
  output logic                    VRD,
  output logic                    VDG,
  output logic                    VOE,
  output logic                    VWE,
  output side_acc_state_t         dbg_state
);

  localparam int CW = $clog2(max_int(SETUP_CYC, STROBE_CYC)) + 1;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);

  side_acc_state_t state_q, state_d;
  logic                    op_wr_q, op_wr_d;
  logic [SIDE_VRAM_AW-1:0] addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic [7:0]              dout_q, dout_d;
  logic                    csn_q, csn_d;
  logic                    vc_q, vc_d;
  logic [SIDE_VRAM_AW-1:0] va_q, va_d;
  logic [7:0]              vd_q, vd_d;
  logic                    vrd_q, vrd_d;
  logic                    vdg_q, vdg_d;
  logic                    voe_q, voe_d;
  logic                    vwe_q, vwe_d;
  logic                    waitn_q, waitn_d;

  logic          req;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

  side_access_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (VIDEO_RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    req      = cpu_cs & (cpu_rd | cpu_wr);
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    dout_d   = dout_q;
    tmr_load = 1'b0;
    tmr_val  = SETUP_LD;

    case (state_q)
      ST_IDLE, ST_PEND: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cpu_slot) begin
          // A simultaneous read+write strobe is treated as a write.
          state_d  = ST_SETUP;
          op_wr_d  = cpu_wr;
          addr_d   = cpu_addr;
          data_d   = cpu_din;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_tc) begin
          if (op_wr_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_DONE;
            dout_d  = VD_in;
          end
        end
      end
      ST_HOLD: state_d = ST_DONE;
      ST_DONE: begin
        if (!cpu_cs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus controls are decoded from the next state so every output is a flop.
    csn_d   = 1'b1;
    vc_d    = 1'b0;
    va_d    = '0;
    vd_d    = 8'hFF;
    vrd_d   = 1'b0;
    vdg_d   = 1'b1;
    voe_d   = 1'b1;
    vwe_d   = 1'b1;
    waitn_d = 1'b1;

    case (state_d)
      ST_PEND: waitn_d = 1'b0;
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        csn_d   = 1'b0;
        vc_d    = 1'b1;
        vdg_d   = 1'b0;
        va_d    = addr_d;
        waitn_d = 1'b0;
        vrd_d   = op_wr_d;
        if (op_wr_d) begin
          vd_d = data_d;
        end else begin
          voe_d = 1'b0;
        end
        if (state_d == ST_STROBE && op_wr_d) begin
          vwe_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dout_q  <= 8'h00;
      csn_q   <= 1'b1;
      vc_q    <= 1'b0;
      va_q    <= '0;
      vd_q    <= 8'hFF;
      vrd_q   <= 1'b0;
      vdg_q   <= 1'b1;
      voe_q   <= 1'b1;
      vwe_q   <= 1'b1;
      waitn_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      csn_q   <= csn_d;
      vc_q    <= vc_d;
      va_q    <= va_d;
      vd_q    <= vd_d;
      vrd_q   <= vrd_d;
      vdg_q   <= vdg_d;
      voe_q   <= voe_d;
      vwe_q   <= vwe_d;
      waitn_q <= waitn_d;
    end
  end

  assign cpu_dout      = dout_q;
  assign cpu_waitn     = waitn_q;
  assign SIDE_VRAM_CSn = csn_q;
  assign V_C           = vc_q;
  assign VA            = va_q;
  assign VD_out        = vd_q;
  assign VRD           = vrd_q;
  assign VDG           = vdg_q;
  assign VOE           = voe_q;
  assign VWE           = vwe_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alphamission_side_vram_access.sv
// Directed bench for the side-VRAM access sequencer: default-timing instance plus
// a SETUP_CYC=2 / STROBE_CYC=3 instance, each attached to a synchronous SRAM model.
module tb_alphamission_side_vram_access;
  import alphamission_side_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_cs, cs2, cpu_rd, cpu_wr, cpu_slot;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;

  logic [7:0]  dout, vd_out, vd_in;
  logic        waitn, csn, v_c, vrd, vdg, voe, vwe;
  logic [10:0] va;
  side_acc_state_t st;

  logic [7:0]  dout2, vd_out2, vd_in2;
  logic        waitn2, csn2, v_c2, vrd2, vdg2, voe2, vwe2;
  logic [10:0] va2;
  side_acc_state_t st2;

  logic [7:0] mem  [0:2047];
  logic [7:0] mem2 [0:2047];
  int write_count;
  int n_checks = 0;
  int n_fail   = 0;

  alphamission_side_vram_access dut (
    .clk(clk), .VIDEO_RST(rst), .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_slot(cpu_slot), .cpu_dout(dout),
    .cpu_waitn(waitn), .SIDE_VRAM_CSn(csn), .V_C(v_c), .VA(va), .VD_out(vd_out),
    .VD_in(vd_in), .VRD(vrd), .VDG(vdg), .VOE(voe), .VWE(vwe), .dbg_state(st)
  );

  alphamission_side_vram_access #(.SETUP_CYC(2), .STROBE_CYC(3)) dut2 (
    .clk(clk), .VIDEO_RST(rst), .cpu_cs(cs2), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_slot(cpu_slot), .cpu_dout(dout2),
    .cpu_waitn(waitn2), .SIDE_VRAM_CSn(csn2), .V_C(v_c2), .VA(va2), .VD_out(vd_out2),
    .VD_in(vd_in2), .VRD(vrd2), .VDG(vdg2), .VOE(voe2), .VWE(vwe2), .dbg_state(st2)
  );

  // Synchronous SRAM models: address sampled on the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) begin
        mem[i]  <= 8'h00;
        mem2[i] <= 8'h00;
      end
      mem2[11'h155] <= 8'h3C;
      write_count   <= 0;
      vd_in         <= 8'hFF;
      vd_in2        <= 8'hFF;
    end else begin
      if (!csn && v_c && !voe) vd_in <= mem[va];
      if (!csn && v_c && !vwe) begin
        mem[va]     <= vd_out;
        write_count <= write_count + 1;
      end
      if (!csn2 && v_c2 && !voe2) vd_in2 <= mem2[va2];
      if (!csn2 && v_c2 && !vwe2) mem2[va2] <= vd_out2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_csn"}, 32'(csn), 32'h1);
    chk({tag, "_vdg"}, 32'(vdg), 32'h1);
    chk({tag, "_voe"}, 32'(voe), 32'h1);
    chk({tag, "_vwe"}, 32'(vwe), 32'h1);
    chk({tag, "_vc"}, 32'(v_c), 32'h0);
    chk({tag, "_vrd"}, 32'(vrd), 32'h0);
    chk({tag, "_va"}, 32'(va), 32'h0);
    chk({tag, "_vd"}, 32'(vd_out), 32'hFF);
    chk({tag, "_waitn"}, 32'(waitn), 32'h1);
  endtask

  initial begin
    // Reset with an active request presented.
    rst = 1'b1; cpu_cs = 1'b1; cs2 = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b1;
    cpu_slot = 1'b1; cpu_addr = 11'h7FF; cpu_din = 8'h00;
    tick(); tick();
    chk_idle_bus("rst");
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_state", 32'(st), 32'(ST_IDLE));
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Write A5 to 3C2.
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h3C2; cpu_din = 8'hA5; cpu_slot = 1'b1;
    tick(); // E0
    chk("wr_e0_csn", 32'(csn), 32'h0);
    chk("wr_e0_vc", 32'(v_c), 32'h1);
    chk("wr_e0_vdg", 32'(vdg), 32'h0);
    chk("wr_e0_vrd", 32'(vrd), 32'h1);
    chk("wr_e0_va", 32'(va), 32'h3C2);
    chk("wr_e0_vd", 32'(vd_out), 32'hA5);
    chk("wr_e0_vwe", 32'(vwe), 32'h1);
    chk("wr_e0_voe", 32'(voe), 32'h1);
    chk("wr_e0_waitn", 32'(waitn), 32'h0);
    cpu_addr = 11'h000; cpu_din = 8'h00; cpu_slot = 1'b0;
    tick(); // E1
    chk("wr_e1_vwe", 32'(vwe), 32'h0);
    chk("wr_e1_voe", 32'(voe), 32'h1);
    chk("wr_e1_waitn", 32'(waitn), 32'h0);
    tick(); // E2
    chk("wr_e2_vwe", 32'(vwe), 32'h1);
    chk("wr_e2_csn", 32'(csn), 32'h0);
    chk("wr_e2_va", 32'(va), 32'h3C2);
    chk("wr_e2_vd", 32'(vd_out), 32'hA5);
    chk("wr_e2_waitn", 32'(waitn), 32'h0);
    chk("wr_e2_mem", 32'(mem[11'h3C2]), 32'hA5);
    chk("wr_e2_count", 32'(write_count), 32'd1);
    tick(); // E3
    chk("wr_e3_waitn", 32'(waitn), 32'h1);
    chk("wr_e3_csn", 32'(csn), 32'h1);
    chk("wr_e3_vd", 32'(vd_out), 32'hFF);
    chk("wr_e3_state", 32'(st), 32'(ST_DONE));

    // cs held high after DONE: no second write even with slot asserted.
    cpu_slot = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("hold_cs_count", 32'(write_count), 32'd1);
    chk("hold_cs_state", 32'(st), 32'(ST_DONE));
    chk("hold_cs_csn", 32'(csn), 32'h1);
    cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_slot = 1'b0;
    tick();
    chk("cs_drop_state", 32'(st), 32'(ST_IDLE));

    // Read back 3C2.
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 11'h3C2; cpu_slot = 1'b1;
    tick(); // E0
    chk("rd_e0_voe", 32'(voe), 32'h0);
    chk("rd_e0_vrd", 32'(vrd), 32'h0);
    chk("rd_e0_csn", 32'(csn), 32'h0);
    chk("rd_e0_va", 32'(va), 32'h3C2);
    chk("rd_e0_vd", 32'(vd_out), 32'hFF);
    chk("rd_e0_vwe", 32'(vwe), 32'h1);
    chk("rd_e0_waitn", 32'(waitn), 32'h0);
    cpu_slot = 1'b0;
    tick(); // E1
    chk("rd_e1_voe", 32'(voe), 32'h0);
    chk("rd_e1_vrd", 32'(vrd), 32'h0);
    chk("rd_e1_waitn", 32'(waitn), 32'h0);
    chk("rd_e1_dout", 32'(dout), 32'h00);
    tick(); // E2
    chk("rd_e2_dout", 32'(dout), 32'hA5);
    chk("rd_e2_waitn", 32'(waitn), 32'h1);
    chk("rd_e2_voe", 32'(voe), 32'h1);
    cpu_cs = 1'b0; cpu_rd = 1'b0;
    tick();

    // Request without a slot: waits in PEND; read+write strobe is a write.
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h07F; cpu_din = 8'h5A;
    cpu_slot = 1'b0;
    tick();
    chk("pend1_state", 32'(st), 32'(ST_PEND));
    chk("pend1_waitn", 32'(waitn), 32'h0);
    chk("pend1_csn", 32'(csn), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    chk("pend5_state", 32'(st), 32'(ST_PEND));
    chk("pend5_waitn", 32'(waitn), 32'h0);
    chk("pend5_csn", 32'(csn), 32'h1);
    chk("pend5_vwe", 32'(vwe), 32'h1);
    cpu_slot = 1'b1;
    tick(); // E0
    chk("pend_e0_state", 32'(st), 32'(ST_SETUP));
    chk("pend_e0_va", 32'(va), 32'h07F);
    chk("pend_e0_vd", 32'(vd_out), 32'h5A);
    chk("pend_e0_vrd", 32'(vrd), 32'h1);
    cpu_slot = 1'b0;
    tick(); tick(); tick(); // E3
    chk("pend_e3_waitn", 32'(waitn), 32'h1);
    chk("pend_e3_mem", 32'(mem[11'h07F]), 32'h5A);
    chk("pend_e3_count", 32'(write_count), 32'd2);
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick();

    // Read an unwritten location so cpu_dout returns to 00.
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 11'h010; cpu_slot = 1'b1;
    tick();
    cpu_slot = 1'b0;
    tick(); tick();
    chk("rd0_dout", 32'(dout), 32'h00);
    chk("rd0_waitn", 32'(waitn), 32'h1);
    cpu_cs = 1'b0; cpu_rd = 1'b0;
    tick();

    // Reset pulsed during a read's SETUP.
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 11'h3C2; cpu_slot = 1'b1;
    tick();
    chk("rrst_setup_state", 32'(st), 32'(ST_SETUP));
    chk("rrst_setup_voe", 32'(voe), 32'h0);
    rst = 1'b1; cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_slot = 1'b0;
    tick();
    chk_idle_bus("rrst");
    chk("rrst_dout", 32'(dout), 32'h00);
    chk("rrst_state", 32'(st), 32'(ST_IDLE));
    rst = 1'b0;
    tick(); tick();
    chk("rrst_after_dout", 32'(dout), 32'h00);
    chk("rrst_after_csn", 32'(csn), 32'h1);

    // SETUP_CYC=2, STROBE_CYC=3 instance: read completes at E5.
    cs2 = 1'b1; cpu_rd = 1'b1; cpu_addr = 11'h155; cpu_slot = 1'b1;
    tick(); // E0
    cpu_slot = 1'b0;
    tick(); // E1
    chk("p2_e1_state", 32'(st2), 32'(ST_SETUP));
    chk("p2_e1_voe", 32'(voe2), 32'h0);
    tick(); // E2
    chk("p2_e2_state", 32'(st2), 32'(ST_STROBE));
    tick(); tick(); // E4
    chk("p2_e4_state", 32'(st2), 32'(ST_STROBE));
    chk("p2_e4_waitn", 32'(waitn2), 32'h0);
    chk("p2_e4_dout", 32'(dout2), 32'h00);
    tick(); // E5
    chk("p2_e5_dout", 32'(dout2), 32'h3C);
    chk("p2_e5_waitn", 32'(waitn2), 32'h1);
    chk("p2_e5_state", 32'(st2), 32'(ST_DONE));
    chk("p2_e5_voe", 32'(voe2), 32'h1);
    cs2 = 1'b0; cpu_rd = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
